// File: rtl/sevenseg_mux_driver.sv
// sevenseg_mux_driver
//   Time-multiplexed driver for an N-digit common-anode 7-segment display.
//   A clock-enable tick (every CLOCK_FREQUENCY/REFRESH_HZ cycles) steps the
//   digit slot. The BCD digits and decimal points are snapshotted once per frame.
//   Leading-zero blanking, PWM brightness and a dead cycle after every tick are
//   applied before the registered outputs.
//
// Ports
//   clk        in   system clock
//   rst_n      in   synchronous reset, active low
//   input_bcd  in   packed BCD digits, digit 0 = rightmost
//   dp_in      in   decimal point request per digit, 1 = lit
//   blank_lz   in   1 = suppress leading zeros
//   brightness in   PWM duty, 0 = off, all ones = full on
//   an         out  anode select, active low
//   seg        out  {g,f,e,d,c,b,a}, active low
//   dp         out  decimal point, active low
//   frame_tick out  one-cycle pulse after each snapshot load
module sevenseg_mux_driver #(
  parameter int unsigned CLOCK_FREQUENCY = 100000000,
  parameter int unsigned REFRESH_HZ      = 1000,
  parameter int unsigned NUM_DIGITS      = 4,
  parameter int unsigned BRIGHT_W        = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_DIGITS-1:0][3:0] input_bcd,
  input  logic [NUM_DIGITS-1:0]      dp_in,
  input  logic                       blank_lz,
  input  logic [BRIGHT_W-1:0]        brightness,
  output logic [NUM_DIGITS-1:0]      an,
  output logic [6:0]                 seg,
  output logic                       dp,
  output logic                       frame_tick
);

  localparam int unsigned TickDiv = CLOCK_FREQUENCY / REFRESH_HZ;
  localparam int unsigned CntW    = (TickDiv > 1) ? $clog2(TickDiv) : 1;
  localparam int unsigned IdxW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("sevenseg_mux_driver: NUM_DIGITS must be in 1..8");
  end
  if (TickDiv < 4) begin : g_bad_tick
    $error("sevenseg_mux_driver: CLOCK_FREQUENCY/REFRESH_HZ must be >= 4");
  end

  logic [CntW-1:0]                r_cnt;
  logic [IdxW-1:0]                r_idx;
  logic [BRIGHT_W-1:0]            r_pwm;
  logic [NUM_DIGITS-1:0][3:0]     r_bcd;
  logic [NUM_DIGITS-1:0]          r_dp;
  logic [NUM_DIGITS-1:0]          r_an;
  logic [6:0]                     r_seg;
  logic                           r_dp_out;
  logic                           r_frame;

  logic                           w_tick;
  logic                           w_last;
  logic                           w_pwm_on;
  logic                           w_lit;
  logic                           w_zero_run;
  logic [NUM_DIGITS-1:0]          w_blank;
  logic [NUM_DIGITS-1:0]          w_an;
  logic [6:0]                     w_seg;
  logic                           w_dp;

  function automatic logic [6:0] f_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;  // non-BCD shows a dash
    endcase
    return s;
  endfunction

  assign w_tick = (r_cnt == CntW'(TickDiv - 1));
  assign w_last = (r_idx == IdxW'(NUM_DIGITS - 1));

  always_comb begin
    // A digit is blanked while it and every digit above it is zero.
    w_zero_run = blank_lz;
    w_blank    = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      w_zero_run = w_zero_run & (r_bcd[i] == 4'd0);
      w_blank[i] = w_zero_run;
    end

    w_pwm_on = (&brightness) | (r_pwm < brightness);
    w_lit    = w_pwm_on & ~w_blank[r_idx];

    w_an  = '1;
    w_seg = f_decode(r_bcd[r_idx]);
    w_dp  = 1'b1;
    if (w_lit) begin
      w_an[r_idx] = 1'b0;
      w_dp        = ~r_dp[r_idx];
    end

    // Anti-ghosting: everything off on the edge that switches digits.
    if (w_tick) begin
      w_an  = '1;
      w_seg = 7'h7F;
      w_dp  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_idx    <= '0;
      r_pwm    <= '0;
      r_bcd    <= '0;
      r_dp     <= '0;
      r_an     <= '1;
      r_seg    <= 7'h7F;
      r_dp_out <= 1'b1;
      r_frame  <= 1'b0;
    end else begin
      r_cnt    <= w_tick ? '0 : r_cnt + 1'b1;
      r_pwm    <= r_pwm + 1'b1;
      r_frame  <= w_tick & w_last;
      r_an     <= w_an;
      r_seg    <= w_seg;
      r_dp_out <= w_dp;
      if (w_tick) begin
        r_idx <= w_last ? '0 : r_idx + 1'b1;
        if (w_last) begin
          r_bcd <= input_bcd;
          r_dp  <= dp_in;
        end
      end
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp_out;
  assign frame_tick = r_frame;

endmodule

// File: tb/tb_sevenseg_mux_driver.sv
module tb_sevenseg_mux_driver;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0][3:0] input_bcd;
  logic [3:0]      dp_in;
  logic            blank_lz;
  logic [3:0]      brightness;
  logic [3:0]      an;
  logic [6:0]      seg;
  logic            dp;
  logic            frame_tick;

  int n_checks = 0;
  int n_err    = 0;

  sevenseg_mux_driver #(
    .CLOCK_FREQUENCY(1000),
    .REFRESH_HZ     (100),
    .NUM_DIGITS     (4),
    .BRIGHT_W       (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .input_bcd (input_bcd),
    .dp_in     (dp_in),
    .blank_lz  (blank_lz),
    .brightness(brightness),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Reference model: k = edges since the reset edge. Each slot is 10 edges,
  // the 10th of which is dead; a frame is 40 edges and the snapshot is taken
  // on every 40th edge.
  logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
  int          k;
  logic [3:0]  sh_bcd [4];
  logic [3:0]  sh_dp;
  logic [12:0] exp_v;
  logic [12:0] got_v;

  task automatic model_reset();
    k = 0;
    for (int j = 0; j < 4; j++) sh_bcd[j] = 4'd0;
    sh_dp = 4'd0;
  endtask

  task automatic model_step();
    int         d;
    int         p;
    bit         pwm_ok;
    bit         blanked;
    bit         lit;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    @(posedge clk);
    #1;
    k++;
    if (k % 10 == 0) begin
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      d       = ((k - 1) / 10) % 4;
      p       = (k - 1) % 16;
      pwm_ok  = (brightness == 4'hF) || (p < int'(brightness));
      blanked = 1'b0;
      if (blank_lz && d > 0) begin
        blanked = 1'b1;
        for (int j = d; j < 4; j++) if (sh_bcd[j] != 4'd0) blanked = 1'b0;
      end
      lit   = pwm_ok && !blanked;
      e_an  = lit ? ~(4'b0001 << d) : 4'hF;
      e_seg = seg_tab[sh_bcd[d]];
      e_dp  = lit ? ~sh_dp[d] : 1'b1;
    end
    exp_v = {e_an, e_seg, e_dp, (k % 40 == 0)};
    got_v = {an, seg, dp, frame_tick};
    if (k % 40 == 0) begin
      for (int j = 0; j < 4; j++) sh_bcd[j] = input_bcd[j];
      sh_dp = dp_in;
    end
  endtask

  task automatic apply_reset(input string name);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    n_checks++;
    if ({an, seg, dp, frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL %s got an=%h seg=%h dp=%b ft=%b required an=F seg=7F dp=1 ft=0",
               name, an, seg, dp, frame_tick);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; input_bcd = '0; dp_in = '0; blank_lz = 1'b0; brightness = 4'hF;
    repeat (2) @(posedge clk);
    apply_reset("reset");
  endtask

  task automatic test_scan();
    input_bcd = {4'd4, 4'd3, 4'd2, 4'd1};
    for (int c = 0; c < 280; c++) begin
      model_step();
      n_checks++;
      if (got_v !== exp_v) begin
        n_err++;
        $display("FAIL scan k=%0d got=%h required=%h", k, got_v, exp_v);
      end
      if (c >= 120 && c % 40 == 17)
        for (int j = 0; j < 4; j++) input_bcd[j] = 4'($urandom_range(0, 9));
    end
  endtask

  task automatic test_blank();
    blank_lz  = 1'b1;
    input_bcd = {4'd0, 4'd0, 4'd0, 4'd7};
    for (int c = 0; c < 360; c++) begin
      model_step();
      n_checks++;
      if (got_v !== exp_v) begin
        n_err++;
        $display("FAIL blank k=%0d got=%h required=%h", k, got_v, exp_v);
      end
      if (c == 80)  input_bcd = '0;
      if (c == 160) blank_lz = 1'b0;
      if (c >= 240 && c % 20 == 3) begin
        blank_lz = 1'($urandom_range(0, 1));
        for (int j = 0; j < 4; j++)
          input_bcd[j] = ($urandom_range(0, 1) != 0) ? 4'd0 : 4'($urandom_range(1, 9));
      end
    end
  endtask

  task automatic test_snapshot();
    blank_lz  = 1'b0;
    input_bcd = {4'd1, 4'd2, 4'd3, 4'd4};
    for (int c = 0; c < 240; c++) begin
      model_step();
      n_checks++;
      if (got_v !== exp_v) begin
        n_err++;
        $display("FAIL snapshot k=%0d got=%h required=%h", k, got_v, exp_v);
      end
      if (c == 55) input_bcd = {4'd5, 4'd6, 4'd7, 4'd8};
      if (c >= 140) begin
        for (int j = 0; j < 4; j++) input_bcd[j] = 4'($urandom_range(0, 9));
        dp_in = 4'($urandom);
      end
    end
    dp_in = '0;
  endtask

  task automatic test_pwm();
    for (int c = 0; c < 400; c++) begin
      if (c == 0)   brightness = 4'd4;
      if (c == 80)  brightness = 4'd0;
      if (c == 160) brightness = 4'hF;
      if (c >= 240 && c % 23 == 0) brightness = 4'($urandom);
      model_step();
      n_checks++;
      if (got_v !== exp_v) begin
        n_err++;
        $display("FAIL pwm k=%0d br=%0d got=%h required=%h", k, brightness, got_v, exp_v);
      end
    end
    brightness = 4'hF;
  endtask

  task automatic test_hex_dp();
    input_bcd = {4'd3, 4'd2, 4'hA, 4'd5};
    dp_in     = 4'b0100;
    for (int c = 0; c < 320; c++) begin
      model_step();
      n_checks++;
      if (got_v !== exp_v) begin
        n_err++;
        $display("FAIL hex_dp k=%0d got=%h required=%h", k, got_v, exp_v);
      end
      if (c >= 120 && c % 13 == 0) begin
        for (int j = 0; j < 4; j++) input_bcd[j] = 4'($urandom);
        dp_in      = 4'($urandom);
        blank_lz   = 1'($urandom_range(0, 1));
        brightness = 4'($urandom);
      end
    end
    brightness = 4'hF; blank_lz = 1'b0;
  endtask

  task automatic test_mid_reset();
    input_bcd = {4'd9, 4'd8, 4'd7, 4'd6};
    dp_in     = 4'b0011;
    // Step into the middle of slot 2.
    for (int c = 0; c < 80 && !(((k / 10) % 4 == 2) && (k % 10 == 4)); c++) model_step();
    n_checks++;
    if (!(((k / 10) % 4 == 2) && (k % 10 == 4))) begin
      n_err++;
      $display("FAIL mid_reset_reach k=%0d required slot 2", k);
    end
    apply_reset("mid_reset");
    for (int c = 0; c < 130; c++) begin
      model_step();
      n_checks++;
      if (got_v !== exp_v) begin
        n_err++;
        $display("FAIL after_reset k=%0d got=%h required=%h", k, got_v, exp_v);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_scan();
    test_blank();
    test_snapshot();
    test_pwm();
    test_hex_dp();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
